// File: rtl/sigdelay_pkg.sv
// Shared types and defaults for the signal-delay sequencing controller.
package sigdelay_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEFAULT = 9;
  localparam int unsigned STATS_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun
  } delay_state_t;

endpackage

// File: rtl/delay_ctrl_if.sv
// Host/datapath signal bundle for delay_ctrl; the stats counters appear only when
// DELAY_CTRL_STATS_EN is defined.
interface delay_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = sigdelay_pkg::ADDRESS_WIDTH_DEFAULT
);
  import sigdelay_pkg::*;

  logic                     start;
  logic                     stop;
  logic                     offset_load;
  logic [ADDRESS_WIDTH-1:0] offset_req;
  logic                     sample_tick;
  logic                     wr;
  logic                     rd;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     out_valid;
  logic                     primed;
  logic                     busy;
`ifdef DELAY_CTRL_STATS_EN
  logic [STATS_W-1:0]       reload_cnt;
  logic [STATS_W-1:0]       drop_cnt;
`endif

  modport master (
    output start, stop, offset_load, offset_req, sample_tick,
    input  wr, rd, offset, out_valid, primed, busy
`ifdef DELAY_CTRL_STATS_EN
    , input reload_cnt, drop_cnt
`endif
  );

  modport slave (
    input  start, stop, offset_load, offset_req, sample_tick,
    output wr, rd, offset, out_valid, primed, busy
`ifdef DELAY_CTRL_STATS_EN
    , output reload_cnt, drop_cnt
`endif
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/delay_ctrl.sv
// Delay-line sequencer: primes the sample RAM with `offset` writes before enabling reads.
// Optional stats counters are built when DELAY_CTRL_STATS_EN is defined.
module delay_ctrl
  import sigdelay_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  delay_ctrl_if.slave bus
);

  delay_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d, fill_inc;
  logic [ADDRESS_WIDTH-1:0] offset_q, offset_d, offset_clamped;
  logic                     wr_q, wr_d, rd_q, rd_d;
  logic                     out_valid_q, out_valid_d;
  logic                     primed_q, busy_q;
  logic                     start_accept, load_accept, tick_drop;

  // Zero would make the read address equal the write address.
  assign offset_clamped = (bus.offset_req == '0) ? ADDRESS_WIDTH'(1) : bus.offset_req;
  assign fill_inc       = fill_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    offset_d     = offset_q;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    out_valid_d  = rd_q;
    start_accept = 1'b0;
    load_accept  = 1'b0;
    tick_drop    = 1'b0;

    if (bus.stop) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d      = StFill;
            offset_d     = offset_clamped;
            fill_cnt_d   = '0;
            start_accept = 1'b1;
          end
        end
        StFill, StRun: begin
          if (bus.offset_load) begin
            state_d     = StFill;
            offset_d    = offset_clamped;
            fill_cnt_d  = '0;
            load_accept = 1'b1;
            tick_drop   = bus.sample_tick;
          end else if (bus.sample_tick) begin
            wr_d = 1'b1;
            if (state_q == StRun) begin
              rd_d = 1'b1;
            end else begin
              fill_cnt_d = fill_inc;
              if (fill_inc == offset_q) state_d = StRun;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      fill_cnt_q  <= '0;
      offset_q    <= ADDRESS_WIDTH'(1);
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      offset_q    <= offset_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      primed_q    <= (state_d == StRun);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign bus.wr        = wr_q;
  assign bus.rd        = rd_q;
  assign bus.offset    = offset_q;
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = primed_q;
  assign bus.busy      = busy_q;

`ifdef DELAY_CTRL_STATS_EN
  sat_counter #(
    .Width(STATS_W)
  ) u_reload_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_accept),
    .inc  (load_accept),
    .count(bus.reload_cnt)
  );

  sat_counter #(
    .Width(STATS_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_accept),
    .inc  (tick_drop),
    .count(bus.drop_cnt)
  );
`else
  logic unused_accept;
  assign unused_accept = start_accept ^ load_accept ^ tick_drop;
`endif

endmodule
